// File: rtl/wireframe_scanfill_pkg.sv
// Shared definitions for the wireframe scan-fill block.
//
// Contents:
//   WF_WIDTH / WF_HEIGHT      wireframe bitmap geometry (columns / rows)
//   WIREFRAME_ADDR_SIZE       SRAM address width, holds WF_WIDTH*WF_HEIGHT-1
//   XW / YW                   pixel column / row widths
//   Color                     RGB565 fill colour
//   PixelOut                  one pixel on the stream: {x, y, colour}
//   fill_state_t              scan-fill FSM states
//   row_base()                address of column 0 of a given row
package defines_package;

    localparam int WF_WIDTH            = 320;
    localparam int WF_HEIGHT           = 240;
    localparam int WIREFRAME_ADDR_SIZE = 17;
    localparam int XW                  = $clog2(WF_WIDTH);
    localparam int YW                  = $clog2(WF_HEIGHT);

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } Color;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        Color          color;
    } PixelOut;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        FILL,
        NEXT,
        FIN
    } fill_state_t;

    // Only used once per triangle to seed the row base; later rows step
    // the base by WF_WIDTH instead of multiplying.
    function automatic logic [WIREFRAME_ADDR_SIZE-1:0] row_base(input logic [YW-1:0] y);
        return WIREFRAME_ADDR_SIZE'(y) * WIREFRAME_ADDR_SIZE'(WF_WIDTH);
    endfunction

endpackage

// File: rtl/wireframe_scanfill_if.sv
// Bus bundle between the scan-fill block and its surroundings.
//
// Groups:
//   control  : start, i_color, i_ymin, i_ymax in; busy, done out
//   sram     : rd_en, rd_addr out, rd_data in (1-cycle read latency);
//              clr_en, clr_addr out (write of a 0)
//   pixels   : px_valid, px_x, px_y, px_color out; px_ready in
//
// Modports:
//   master   : the scan-fill block
//   slave    : the environment (SRAM, rasterizer control, framebuffer writer)
interface wireframe_scanfill_if;
    import defines_package::*;

    logic                           start;
    Color                           i_color;
    logic [YW-1:0]                  i_ymin;
    logic [YW-1:0]                  i_ymax;

    logic                           rd_en;
    logic [WIREFRAME_ADDR_SIZE-1:0] rd_addr;
    logic                           rd_data;
    logic                           clr_en;
    logic [WIREFRAME_ADDR_SIZE-1:0] clr_addr;

    logic                           px_valid;
    logic                           px_ready;
    logic [XW-1:0]                  px_x;
    logic [YW-1:0]                  px_y;
    Color                           px_color;

    logic                           busy;
    logic                           done;

    modport master (
        input  start, i_color, i_ymin, i_ymax, rd_data, px_ready,
        output rd_en, rd_addr, clr_en, clr_addr,
               px_valid, px_x, px_y, px_color, busy, done
    );

    modport slave (
        output start, i_color, i_ymin, i_ymax, rd_data, px_ready,
        input  rd_en, rd_addr, clr_en, clr_addr,
               px_valid, px_x, px_y, px_color, busy, done
    );

endinterface

// File: rtl/wireframe_scanfill.sv
// Wireframe scan-fill: reads the rasterizer's wireframe bitmap row by row
// over [ymin, ymax], finds the leftmost/rightmost set bit of each row,
// emits every pixel of that span on a ready/valid stream, and clears each
// set bit as it is read so the bitmap is empty for the next triangle.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - wireframe_scanfill_if.master (control, SRAM read/clear, pixels)
module wireframe_scanfill
    import defines_package::*;
(
    input  logic                 clk,
    input  logic                 rst,
    wireframe_scanfill_if.master bus
);

    localparam int AW = WIREFRAME_ADDR_SIZE;

    fill_state_t   state;
    Color          color;
    logic [YW-1:0] y;
    logic [YW-1:0] ymax;
    logic [XW-1:0] x;
    logic [AW-1:0] base;

    logic          found;
    logic [XW-1:0] xmin;
    logic [XW-1:0] xmax;

    logic          rd_en;
    logic [AW-1:0] rd_addr;

    // Column/address of the read whose data arrives this cycle.
    logic          pend_valid;
    logic [XW-1:0] pend_x;
    logic [AW-1:0] pend_addr;

    PixelOut       px;
    logic          px_valid;
    logic          busy;
    logic          done;

    logic [YW-1:0] ymax_clamped;
    logic          hit;
    logic          found_now;
    logic [XW-1:0] xmin_now;
    logic          handshake;
    logic [AW-1:0] start_base;
    logic [AW-1:0] next_base;

    // found_now/xmin_now fold in the response arriving this cycle, so the
    // DRAIN decision already sees the bit read at the last column.
    always_comb begin
        ymax_clamped = (bus.i_ymax > YW'(WF_HEIGHT - 1)) ? YW'(WF_HEIGHT - 1) : bus.i_ymax;
        hit          = pend_valid & bus.rd_data;
        found_now    = found | hit;
        xmin_now     = found ? xmin : pend_x;
        handshake    = px_valid & bus.px_ready;
        start_base   = row_base(bus.i_ymin);
        next_base    = base + AW'(WF_WIDTH);
    end

    // The clear has to land in the same cycle as the data it answers, so
    // it is decoded straight from the pipeline stage rather than registered.
    assign bus.clr_en   = hit;
    assign bus.clr_addr = hit ? pend_addr : '0;

    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = rd_addr;
    assign bus.px_valid = px_valid;
    assign bus.px_x     = px.x;
    assign bus.px_y     = px.y;
    assign bus.px_color = px.color;
    assign bus.busy     = busy;
    assign bus.done     = done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            color      <= '0;
            y          <= '0;
            ymax       <= '0;
            x          <= '0;
            base       <= '0;
            found      <= 1'b0;
            xmin       <= '0;
            xmax       <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            pend_valid <= 1'b0;
            pend_x     <= '0;
            pend_addr  <= '0;
            px         <= '0;
            px_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            pend_valid <= rd_en;
            pend_x     <= x;
            pend_addr  <= rd_addr;

            if (hit) begin
                if (!found) begin
                    xmin <= pend_x;
                end
                found <= 1'b1;
                xmax  <= pend_x;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        color <= bus.i_color;
                        ymax  <= ymax_clamped;
                        busy  <= 1'b1;
                        if (bus.i_ymin > ymax_clamped) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            y       <= bus.i_ymin;
                            x       <= '0;
                            found   <= 1'b0;
                            base    <= start_base;
                            rd_en   <= 1'b1;
                            rd_addr <= start_base;
                            state   <= SCAN;
                        end
                    end
                end

                // x is the column currently on rd_addr.
                SCAN: begin
                    if (x == XW'(WF_WIDTH - 1)) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        x       <= x + 1'b1;
                        rd_addr <= rd_addr + 1'b1;
                    end
                end

                DRAIN: begin
                    if (found_now) begin
                        px.x     <= xmin_now;
                        px.y     <= y;
                        px.color <= color;
                        px_valid <= 1'b1;
                        state    <= FILL;
                    end else begin
                        state <= NEXT;
                    end
                end

                FILL: begin
                    if (handshake) begin
                        if (px.x == xmax) begin
                            px_valid <= 1'b0;
                            state    <= NEXT;
                        end else begin
                            px.x <= px.x + 1'b1;
                        end
                    end
                end

                NEXT: begin
                    if (y == ymax) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        y       <= y + 1'b1;
                        x       <= '0;
                        found   <= 1'b0;
                        base    <= next_base;
                        rd_en   <= 1'b1;
                        rd_addr <= next_base;
                        state   <= SCAN;
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wireframe_scanfill.sv
// Self-checking bench for wireframe_scanfill: a bitmap SRAM model with a
// one-cycle read, a scoreboard of expected pixels and clear addresses
// predicted from the bitmap before each start, and directed scenarios.
module tb_wireframe_scanfill;
    import defines_package::*;

    localparam int NPIX = WF_WIDTH * WF_HEIGHT;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wireframe_scanfill_if bus();

    wireframe_scanfill dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Bitmap SRAM: one-cycle synchronous read, clear port, and a bench-only
    // set port used to draw test patterns.
    bit                             mem [NPIX];
    logic                           set_en;
    logic [WIREFRAME_ADDR_SIZE-1:0] set_addr;

    always @(posedge clk) begin
        if (bus.rd_en && int'(bus.rd_addr) < NPIX) bus.rd_data <= mem[int'(bus.rd_addr)];
        if (bus.clr_en && int'(bus.clr_addr) < NPIX) mem[int'(bus.clr_addr)] <= 1'b0;
        if (set_en) mem[int'(set_addr)] <= 1'b1;
    end

    int checks = 0;
    int errors = 0;

    logic [63:0] px_q[$];
    int          clr_q[$];

    int hs_cnt  = 0;
    int pxv_cnt = 0;
    int rd_cnt  = 0;
    int clr_cnt = 0;

    bit          hold_pending = 1'b0;
    logic [63:0] held;

    function automatic logic [63:0] pack_px(input logic [8:0] x, input logic [7:0] y, input Color c);
        return {31'b0, x, y, c};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctrl"}, 64'({bus.rd_en, bus.clr_en, bus.px_valid, bus.busy, bus.done}), 64'd0);
        checkOutput({tag, "_addr"}, 64'({bus.rd_addr, bus.clr_addr}), 64'd0);
        checkOutput({tag, "_px"}, pack_px(bus.px_x, bus.px_y, bus.px_color), 64'd0);
    endtask

    // Scoreboard: every handshake and every clear is checked against the
    // front of its queue; a stalled pixel must be unchanged next cycle.
    always @(negedge clk) begin
        logic [63:0] exp_v;
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("px_hold_valid", 64'(bus.px_valid), 64'd1);
                checkOutput("px_hold_data", pack_px(bus.px_x, bus.px_y, bus.px_color), held);
                hold_pending = 1'b0;
            end
            if (bus.rd_en) rd_cnt++;
            if (bus.clr_en) begin
                clr_cnt++;
                if (clr_q.size() > 0) exp_v = 64'(clr_q.pop_front());
                else exp_v = 64'hFFFF_FFFF;
                checkOutput("clr_addr", 64'(bus.clr_addr), exp_v);
            end
            if (bus.px_valid) begin
                pxv_cnt++;
                if (bus.px_ready) begin
                    hs_cnt++;
                    if (px_q.size() > 0) exp_v = px_q.pop_front();
                    else exp_v = '1;
                    checkOutput("px_data", pack_px(bus.px_x, bus.px_y, bus.px_color), exp_v);
                end else begin
                    hold_pending = 1'b1;
                    held         = pack_px(bus.px_x, bus.px_y, bus.px_color);
                end
            end
        end
    end

    task automatic setBit(input int x, input int y);
        @(posedge clk);
        #1;
        set_en   = 1'b1;
        set_addr = WIREFRAME_ADDR_SIZE'(y * WF_WIDTH + x);
        @(posedge clk);
        #1;
        set_en = 1'b0;
    endtask

    // Reference model: expected clears in scan order and the filled span
    // of each row, taken from the bitmap as it stands before the start.
    task automatic predict(input int ymin, input int ymax_in, input Color c);
        int ymax, xmin, xmax, a;
        ymax = (ymax_in > WF_HEIGHT - 1) ? WF_HEIGHT - 1 : ymax_in;
        for (int yy = ymin; yy <= ymax; yy++) begin
            xmin = -1;
            xmax = -1;
            for (int xx = 0; xx < WF_WIDTH; xx++) begin
                a = yy * WF_WIDTH + xx;
                if (mem[a]) begin
                    clr_q.push_back(a);
                    if (xmin < 0) xmin = xx;
                    xmax = xx;
                end
            end
            if (xmin >= 0)
                for (int xx = xmin; xx <= xmax; xx++)
                    px_q.push_back(pack_px(9'(xx), 8'(yy), c));
        end
    endtask

    task automatic startScan(input int ymin, input int ymax, input Color c);
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.i_ymin  = 8'(ymin);
        bus.i_ymax  = 8'(ymax);
        bus.i_color = c;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.i_color = Color'(~c);
        bus.px_ready = 1'b1;
    endtask

    // exp_lat < 0 skips the latency check (used when px_ready toggles).
    task automatic applyStimulus(input string name, input int ymin, input int ymax, input Color c,
                                 input bit toggle, input int exp_lat, input int exp_px,
                                 input int exp_clr, input int exp_rd);
        int hs0, clr0, rd0, cycles;
        predict(ymin, ymax, c);
        hs0  = hs_cnt;
        clr0 = clr_cnt;
        rd0  = rd_cnt;
        startScan(ymin, ymax, c);
        cycles = 1;
        @(negedge clk);
        while (!bus.done && cycles < 5000) begin
            @(posedge clk);
            #1;
            if (toggle) bus.px_ready = ~bus.px_ready;
            @(negedge clk);
            cycles++;
        end
        checkOutput({name, "_done_seen"}, 64'(bus.done), 64'd1);
        if (exp_lat >= 0) checkOutput({name, "_latency"}, 64'(cycles), 64'(exp_lat));
        checkOutput({name, "_busy_fin"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, 64'(bus.done), 64'd0);
        checkOutput({name, "_busy_after"}, 64'(bus.busy), 64'd0);
        checkOutput({name, "_handshakes"}, 64'(hs_cnt - hs0), 64'(exp_px));
        checkOutput({name, "_clears"}, 64'(clr_cnt - clr0), 64'(exp_clr));
        checkOutput({name, "_reads"}, 64'(rd_cnt - rd0), 64'(exp_rd));
        checkOutput({name, "_px_left"}, 64'(px_q.size()), 64'd0);
        checkOutput({name, "_clr_left"}, 64'(clr_q.size()), 64'd0);
        bus.px_ready = 1'b1;
        $display("[TB] %s finished after %0d cycles", name, cycles);
    endtask

    initial begin
        int pv0, waited;
        rst          = 1'b1;
        set_en       = 1'b0;
        set_addr     = '0;
        bus.start    = 1'b0;
        bus.i_ymin   = '0;
        bus.i_ymax   = '0;
        bus.i_color  = '0;
        bus.px_ready = 1'b1;

        #12;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two bits on row 5: span 10..20, 11 pixels, clears 1610/1620.
        setBit(10, 5);
        setBit(20, 5);
        applyStimulus("row5", 5, 5, Color'(16'hF81F), 1'b0, 322 + 11 + 1, 11, 2, 320);

        // Empty bitmap over three rows.
        applyStimulus("empty", 0, 2, Color'(16'h07E0), 1'b0, 3 * (321 + 1) + 1, 0, 0, 960);

        // Bottom-right corner pixel, address 76799.
        setBit(319, 239);
        applyStimulus("corner", 239, 239, Color'(16'h001F), 1'b0, 322 + 1 + 1, 1, 1, 320);

        // Back-pressure: px_ready alternates during a 3..6 span.
        setBit(3, 7);
        setBit(6, 7);
        applyStimulus("toggle", 7, 7, Color'(16'h1234), 1'b1, -1, 4, 2, 320);

        // Inverted range: straight to done, no SRAM traffic.
        applyStimulus("inverted", 10, 4, Color'(16'hABCD), 1'b0, 1, 0, 0, 0);

        // ymax beyond the bitmap is clamped to row 239.
        setBit(100, 239);
        applyStimulus("clamp", 238, 250, Color'(16'h5555), 1'b0, 322 + 323 + 1, 1, 1, 640);

        // Reset in the middle of a fill, then rescan the same rows.
        setBit(30, 20);
        setBit(50, 20);
        setBit(7, 21);
        predict(20, 21, Color'(16'h0F0F));
        startScan(20, 21, Color'(16'h0F0F));
        waited = 0;
        @(negedge clk);
        while (!(bus.px_valid && bus.px_x == 9'd35) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("midfill_reached", 64'(bus.px_valid && bus.px_x == 9'd35), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("midfill_rst");
        px_q.delete();
        clr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pv0 = pxv_cnt;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_partial_span", 64'(pxv_cnt - pv0), 64'd0);
        checkOutput("row20_cleared", 64'({mem[20 * WF_WIDTH + 30], mem[20 * WF_WIDTH + 50]}), 64'd0);
        applyStimulus("rescan", 20, 21, Color'(16'h0F0F), 1'b0, 322 + 323 + 1, 1, 1, 640);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
